regfile_burst_reader: RTL and testbench

Read-side engine for the 8x16 register file. It accepts a burst read request (start address plus length) over a valid/ready handshake and issues single-cycle synchronous reads to the register file's read port. It returns the words in order on a valid/ready output stream with a last-word marker. A 2-entry output buffer absorbs the one-cycle read latency and downstream backpressure without losing or duplicating words.

---
 rtl/regfile_burst_reader.sv | 142 ++++++++++++++
 tb/tb_regfile_burst_reader.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_burst_reader.sv
// Burst read engine for an 8x16 register file. A request (start address,
// length-1) is accepted in IDLE; reads are issued one per cycle to the
// register file's synchronous read port, gated by a 2-credit check that
// counts buffered words plus the read in flight. Returned words land in a
// 2-entry FIFO that drives the output stream together with a last marker.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid (and its payload) never depends combinationally on ready,
// and a stalled word (valid=1, ready=0) keeps its payload stable.
module regfile_burst_reader #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [ADDR_W-1:0] req_len,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [WIDTH-1:0]  rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_last,
  output logic              busy,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_cnt;
  logic [ADDR_W-1:0] rem_cnt;
  logic              inflight;
  logic              inflight_last;
  logic [WIDTH-1:0]  fifo_data [2];
  logic              fifo_last [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic              push;
  logic              pop;
  logic              accept;
  logic              issue_last;
  logic [2:0]        credit_sum;
  logic              credit_ok;

  assign out_valid  = (count != 2'd0);
  assign out_data   = fifo_data[rd_ptr];
  assign out_last   = fifo_last[rd_ptr];
  assign pop        = out_valid & out_ready;
  assign push       = inflight;
  assign req_ready  = (state == IDLE);
  assign accept     = req_valid & req_ready;
  assign busy       = (state != IDLE);
  assign fsm_state  = state;
  assign rd_addr    = (state == IDLE) ? '0 : addr_cnt;
  assign issue_last = rd_en & (rem_cnt == '0);

  // pop requires count >= 1, so this sum cannot underflow
  assign credit_sum = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign credit_ok  = (credit_sum < 3'd2);

  // Next-state and read-strobe decode
  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = READ;
      end
      READ: begin
        rd_en = credit_ok;
        if (credit_ok && (rem_cnt == '0)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (pop && out_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Address / remaining-issue counters; address wraps naturally at DEPTH
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_cnt <= '0;
      rem_cnt  <= '0;
    end else if (accept) begin
      addr_cnt <= req_addr;
      rem_cnt  <= req_len;
    end else if (rd_en) begin
      addr_cnt <= addr_cnt + 1'b1;
      rem_cnt  <= rem_cnt - 1'b1;
    end
  end

  // In-flight read flag and its last tag, aligned with rd_data arrival
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= rd_en;
      inflight_last <= issue_last;
    end
  end

  // 2-entry output FIFO; simultaneous push and pop leaves count unchanged
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
      fifo_last[0] <= 1'b0;
      fifo_last[1] <= 1'b0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      count        <= 2'd0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= rd_data;
        fifo_last[wr_ptr] <= inflight_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_regfile_burst_reader.sv
// Bench for regfile_burst_reader: a register-file model answers reads, a
// scoreboard predicts the word/address sequence of each accepted burst from
// the request alone, and directed plus randomized bursts exercise timing,
// wrap-around, backpressure, ignored requests and mid-burst reset.
module tb_regfile_burst_reader;
  localparam int W = 8;
  localparam int D = 16;
  localparam int A = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [A-1:0] req_addr = '0;
  logic [A-1:0] req_len = '0;
  logic         rd_en;
  logic [A-1:0] rd_addr;
  logic [W-1:0] rd_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
  logic         out_last;
  logic         busy;
  logic [1:0]   fsm_state;

  regfile_burst_reader #(.WIDTH(W), .DEPTH(D), .ADDR_W(A)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy), .fsm_state(fsm_state)
  );

  // ---------------- clock / register file model ----------------
  always #5 clk = ~clk;

  logic [W-1:0] mem [D];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [W:0]   exp_q[$];       // {last, data}
  logic [A-1:0] exp_addr_q[$];
  int  acc_cyc, first_valid_cyc, last_pop_cyc, valid_cycles, n_acc;
  int  issued, popped;
  bit  seen_valid;
  bit  chk_first_idle = 0;
  logic stall_prev;
  logic [W:0] stall_val;
  logic prev_busy;

  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      exp_addr_q.delete();
      issued = 0; popped = 0; stall_prev = 0; prev_busy = 0; seen_valid = 0;
    end else begin
      if (rd_en) begin
        issued++;
        if (exp_addr_q.size() == 0) check("rd_en_unexpected", 1, 0);
        else check("rd_addr", rd_addr, exp_addr_q.pop_front());
      end
      if (out_valid) begin
        valid_cycles++;
        if (!seen_valid) begin seen_valid = 1; first_valid_cyc = cyc; end
      end
      if (stall_prev) begin
        check("stall_valid", out_valid, 1);
        check("stall_hold", {out_last, out_data}, stall_val);
      end
      if (out_valid && out_ready) begin
        popped++;
        if (exp_q.size() == 0) check("pop_unexpected", 1, 0);
        else begin
          logic [W:0] e;
          e = exp_q.pop_front();
          check("out_word", {out_last, out_data}, e);
          if (e[W]) last_pop_cyc = cyc;
        end
      end
      if (rd_en || (out_valid && out_ready))
        check("outstanding_le2", ((issued - popped) <= 2), 1);
      if (req_valid && busy) check("req_ready_busy", req_ready, 0);
      stall_prev = out_valid && !out_ready;
      stall_val  = {out_last, out_data};
      if (req_valid && req_ready) begin
        if (chk_first_idle) check("accept_first_idle", prev_busy, 1);
        n_acc++;
        acc_cyc = cyc + 1;
        seen_valid = 0;
        valid_cycles = 0;
        for (int i = 0; i <= int'(req_len); i++) begin
          logic [A-1:0] a;
          a = req_addr + i[A-1:0];
          exp_addr_q.push_back(a);
          exp_q.push_back({(i == int'(req_len)), mem[a]});
        end
      end
      prev_busy = busy;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset_outputs();
    check("rst_req_ready", req_ready, 1);
    check("rst_rd_en", rd_en, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
  endtask

  task automatic send_req(input logic [A-1:0] addr, input logic [A-1:0] len);
    int t = 0;
    req_valid = 1'b1; req_addr = addr; req_len = len;
    while (!req_ready && t < 100) begin @(posedge clk); #1; t++; end
    check("req_timeout", (t < 100), 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("busy_after_acc", busy, 1);
    check("req_ready_after_acc", req_ready, 0);
  endtask

  task automatic wait_done(input bit rand_ready);
    int t = 0;
    while (t < 400 && !(exp_q.size() == 0 && req_ready)) begin
      @(posedge clk); #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      t++;
    end
    check("done_timeout", (t < 400), 1);
    check("busy_low_done", busy, 0);
    out_ready = 1'b1;
  endtask

  // Timing for a burst of n words drained with out_ready held high
  task automatic check_timing(input int n);
    check("first_latency", first_valid_cyc - acc_cyc, 2);
    check("last_pop_cycle", last_pop_cyc - acc_cyc, n + 1);
    check("valid_cycles", valid_cycles, n);
    check("idle_after_last", cyc - last_pop_cyc, 1);
  endtask

  task automatic fill_random();
    for (int i = 0; i < D; i++) mem[i] = W'($urandom);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    fill_random();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs();
    rst = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // single word
    mem[5] = 8'hA5;
    send_req(4'd5, 4'd0);
    wait_done(0);
    check_timing(1);

    // wrap-around
    for (int i = 0; i < D; i++) mem[i] = W'(i + 8'h10);
    send_req(4'd14, 4'd3);
    wait_done(0);
    check_timing(4);

    // full burst with random backpressure
    fill_random();
    send_req(4'd0, 4'd15);
    wait_done(1);

    // request while busy: held second request waits for IDLE
    begin
      int t = 0;
      int acc0;
      acc0 = n_acc;
      send_req(4'd2, 4'd4);
      req_valid = 1'b1; req_addr = 4'd9; req_len = 4'd2;
      chk_first_idle = 1;
      while (n_acc < acc0 + 2 && t < 100) begin @(posedge clk); #1; t++; end
      check("second_req_accepted", n_acc - acc0, 2);
      req_valid = 1'b0;
      chk_first_idle = 0;
      wait_done(0);
    end

    // throughput
    fill_random();
    send_req(4'd3, 4'd7);
    wait_done(0);
    check_timing(8);

    // randomized bursts
    for (int k = 0; k < 8; k++) begin
      fill_random();
      send_req(A'($urandom_range(0, D - 1)), A'($urandom_range(0, D - 1)));
      wait_done(1);
    end

    // reset mid-burst
    out_ready = 1'b0;
    send_req(4'd0, 4'd15);
    repeat (4) @(posedge clk);
    #1 check("pre_reset_valid", out_valid, 1);
    rst = 1'b0;
    #1 check_reset_outputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    out_ready = 1'b1;
    fill_random();
    send_req(4'd6, 4'd5);
    wait_done(0);
    check_timing(6);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
